// File: rtl/keccak_input_buffer.sv
// keccak_input_buffer: collects 64-bit message words into a 17-word rate block, applies pad10*1, and hands it off by valid/ack.
// Defining KECCAK_INPUT_BUFFER_OVERFLOW_CHK_EN adds a sticky Overflow flag for writes dropped while full.
module keccak_input_buffer #(
  parameter int N          = 64,
  parameter int RATE_WORDS = 17
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic [N-1:0]            Din,
  input  logic                    Din_valid,
  input  logic                    Last_block,
  output logic                    Buffer_full,
  output logic [N*RATE_WORDS-1:0] Block_out,
  output logic                    Block_valid,
  output logic                    Block_last,
`ifdef KECCAK_INPUT_BUFFER_OVERFLOW_CHK_EN
  output logic                    Overflow,
`endif
  input  logic                    Block_ack
);
  localparam int CW = $clog2(RATE_WORDS + 1);
  localparam logic [CW-1:0] RW = CW'(RATE_WORDS);
  localparam logic [N-1:0] LO = N'(1);
  localparam logic [N-1:0] HI = {1'b1, {(N-1){1'b0}}};
  typedef enum logic [1:0] {FILL, FULL, FULL_PAD} state_t;
  state_t state;
  logic [CW-1:0] cnt, c;
  logic [N-1:0] words [RATE_WORDS];
  logic [N-1:0] fill_w [RATE_WORDS];
  logic [N-1:0] pad_w [RATE_WORDS];
  logic [N-1:0] pure_w [RATE_WORDS];
  // Unwritten words are always zero, so the pad marks can be XORed straight in.
  always_comb begin
    c = cnt + CW'(Din_valid);
    for (int i = 0; i < RATE_WORDS; i++) begin
      fill_w[i] = (Din_valid && CW'(i) == cnt) ? Din : words[i];
      pad_w[i]  = fill_w[i] ^ ((c != RW && CW'(i) == c) ? LO : '0)
                            ^ ((c != RW && i == RATE_WORDS-1) ? HI : '0);
      pure_w[i] = (i == 0 ? LO : '0) ^ (i == RATE_WORDS-1 ? HI : '0);
    end
  end
  for (genvar g = 0; g < RATE_WORDS; g++) begin : g_out
    assign Block_out[N*g +: N] = words[g];
  end
  always_ff @(posedge Clock) begin
    if (Reset || Start) begin
      state       <= FILL;
      cnt         <= '0;
      words       <= '{default: '0};
      Buffer_full <= 1'b0;
      Block_valid <= 1'b0;
      Block_last  <= 1'b0;
`ifdef KECCAK_INPUT_BUFFER_OVERFLOW_CHK_EN
      Overflow    <= 1'b0;
`endif
    end else begin
      unique case (state)
        FILL:
          if (Last_block) begin
            words       <= pad_w;
            cnt         <= '0;
            state       <= (c == RW) ? FULL_PAD : FULL;
            Buffer_full <= 1'b1;
            Block_valid <= 1'b1;
            Block_last  <= (c != RW);
          end else if (Din_valid) begin
            words <= fill_w;
            cnt   <= cnt + 1'b1;
            if (cnt == RW - 1'b1) begin
              state       <= FULL;
              Buffer_full <= 1'b1;
              Block_valid <= 1'b1;
            end
          end
        FULL:
          if (Block_ack) begin
            words       <= '{default: '0};
            cnt         <= '0;
            state       <= FILL;
            Buffer_full <= 1'b0;
            Block_valid <= 1'b0;
            Block_last  <= 1'b0;
          end
        FULL_PAD:
          if (Block_ack) begin
            words      <= pure_w;
            state      <= FULL;
            Block_last <= 1'b1;
          end
        default: state <= FILL;
      endcase
`ifdef KECCAK_INPUT_BUFFER_OVERFLOW_CHK_EN
      if (state != FILL && (Din_valid || Last_block)) Overflow <= 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_keccak_input_buffer.sv
// tb_keccak_input_buffer: directed vectors with hand-computed expectations for keccak_input_buffer.
module tb_keccak_input_buffer;
  logic Clock = 1'b0, Reset = 1'b0, Start = 1'b0, Din_valid = 1'b0, Last_block = 1'b0, Block_ack = 1'b0;
  logic [63:0] Din = '0;
  logic Buffer_full, Block_valid, Block_last;
  logic [64*17-1:0] Block_out;
`ifdef KECCAK_INPUT_BUFFER_OVERFLOW_CHK_EN
  logic Overflow;
`endif
  int n_chk = 0, n_pass = 0;
  localparam logic [63:0] AA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] HI = 64'h8000_0000_0000_0000;
  keccak_input_buffer dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Din(Din), .Din_valid(Din_valid),
    .Last_block(Last_block), .Buffer_full(Buffer_full), .Block_out(Block_out),
    .Block_valid(Block_valid), .Block_last(Block_last),
`ifdef KECCAK_INPUT_BUFFER_OVERFLOW_CHK_EN
    .Overflow(Overflow),
`endif
    .Block_ack(Block_ack)
  );
  always #5 Clock = ~Clock;
  function automatic logic [63:0] w(int i);
    return Block_out[64*i +: 64];
  endfunction
  function automatic logic [63:0] mid_or(int lo, int hi);
    logic [63:0] r = '0;
    for (int i = lo; i <= hi; i++) r |= w(i);
    return r;
  endfunction
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge Clock);
    #1;
  endtask
  task automatic put(logic [63:0] d, logic last);
    Din = d; Din_valid = 1'b1; Last_block = last;
    step();
    Din_valid = 1'b0; Last_block = 1'b0;
  endtask
  task automatic pulse_start();
    Start = 1'b1; step(); Start = 1'b0;
  endtask
  task automatic ack();
    Block_ack = 1'b1; step(); Block_ack = 1'b0;
  endtask
  task automatic close();
    Last_block = 1'b1; step(); Last_block = 1'b0;
  endtask
  task automatic flags(string tag, logic f, logic v, logic l);
    check({tag, "_full"}, 64'(Buffer_full), 64'(f));
    check({tag, "_valid"}, 64'(Block_valid), 64'(v));
    check({tag, "_last"}, 64'(Block_last), 64'(l));
  endtask
  task automatic seventeen(string tag);
    for (int i = 0; i < 17; i++) begin
      if (i == 16) check({tag, "_not_full_16"}, 64'(Buffer_full), 64'h0);
      put(64'(i), 1'b0);
    end
    flags(tag, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) check($sformatf("%s_w%0d", tag, i), w(i), 64'(i));
  endtask
  initial begin
    Reset = 1'b1; step(); step(); Reset = 1'b0;
    flags("rst", 1'b0, 1'b0, 1'b0);
    check("rst_blk", mid_or(0, 16), 64'h0);
`ifdef KECCAK_INPUT_BUFFER_OVERFLOW_CHK_EN
    check("rst_ovf", 64'(Overflow), 64'h0);
`endif
    pulse_start();
    seventeen("s1");
    ack();
    flags("s1_ack", 1'b0, 1'b0, 1'b0);
    check("s1_ack_blk", mid_or(0, 16), 64'h0);
    // three words then Last_block alone; a stray ack while idle must be ignored
    pulse_start();
    put(AA, 1'b0);
    ack();
    put(AA, 1'b0); put(AA, 1'b0);
    check("s2_pre_full", 64'(Buffer_full), 64'h0);
    close();
    flags("s2", 1'b1, 1'b1, 1'b1);
    check("s2_w0", w(0), AA);
    check("s2_w2", w(2), AA);
    check("s2_w3", w(3), 64'h1);
    check("s2_mid", mid_or(4, 15), 64'h0);
    check("s2_w16", w(16), HI);
    ack();
    flags("s2_ack", 1'b0, 1'b0, 1'b0);
    // 16 words then Last_block alone: both marks share word 16
    pulse_start();
    for (int i = 0; i < 16; i++) put(64'h100 + 64'(i), 1'b0);
    close();
    flags("s3", 1'b1, 1'b1, 1'b1);
    check("s3_w0", w(0), 64'h100);
    check("s3_w15", w(15), 64'h10F);
    check("s3_w16", w(16), 64'h8000_0000_0000_0001);
    ack();
    // 17th word with Last_block: data block then a pure padding block
    pulse_start();
    for (int i = 0; i < 16; i++) put(64'h200 + 64'(i), 1'b0);
    put(64'h210, 1'b1);
    flags("s4a", 1'b1, 1'b1, 1'b0);
    check("s4a_w0", w(0), 64'h200);
    check("s4a_w16", w(16), 64'h210);
    Din = 64'hDEAD; Din_valid = 1'b1;
    repeat (5) step();
    Din_valid = 1'b0;
    flags("s4_drop", 1'b1, 1'b1, 1'b0);
    check("s4_drop_w0", w(0), 64'h200);
    check("s4_drop_w7", w(7), 64'h207);
    check("s4_drop_w16", w(16), 64'h210);
`ifdef KECCAK_INPUT_BUFFER_OVERFLOW_CHK_EN
    check("s4_ovf", 64'(Overflow), 64'h1);
`endif
    ack();
    flags("s4b", 1'b1, 1'b1, 1'b1);
    check("s4b_w0", w(0), 64'h1);
    check("s4b_mid", mid_or(1, 15), 64'h0);
    check("s4b_w16", w(16), HI);
    ack();
    flags("s4_done", 1'b0, 1'b0, 1'b0);
    check("s4_done_blk", mid_or(0, 16), 64'h0);
    // Reset while a padding block is still owed
    pulse_start();
    for (int i = 0; i < 16; i++) put(64'h300 + 64'(i), 1'b0);
    put(64'h310, 1'b1);
    check("s5_pre_full", 64'(Buffer_full), 64'h1);
    Reset = 1'b1; step(); Reset = 1'b0;
    flags("s5_rst", 1'b0, 1'b0, 1'b0);
    check("s5_rst_blk", mid_or(0, 16), 64'h0);
`ifdef KECCAK_INPUT_BUFFER_OVERFLOW_CHK_EN
    check("s5_rst_ovf", 64'(Overflow), 64'h0);
`endif
    seventeen("s5");
    ack();
    flags("s5_ack", 1'b0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/keccak_input_buffer.md
Name: keccak_input_buffer

Overview:
- Receiving end of the Keccak message-input protocol: Start / Din / Din_valid / Last_block in, Buffer_full out.
- Accumulates 64-bit message words into one rate-sized block (17 words = 1088 bits) and applies Keccak pad10*1 on Last_block.
- Presents the complete block to the permutation core through a valid/ack handshake.
- Sits between the host-side driver and the keccak round engine.

Parameters:
- N, 64, message word width in bits (from pkg_keccak).
- RATE_WORDS, 17, words per rate block.

Ports:
- Clock  input  1  system clock, all logic on rising edge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  one-cycle pulse; begins a new message (synchronous clear of buffer state)
- Din  input  N  message word
- Din_valid  input  1  Din is written this cycle
- Last_block  input  1  one-cycle pulse; message ended, pad and close current block
- Buffer_full  output  1  block complete and awaiting consumption; writes not accepted
- Block_out  output  N*RATE_WORDS  assembled block; word i at bits [N*i +: N]
- Block_valid  output  1  Block_out is stable and ready for the permutation
- Block_last  output  1  qualifies Block_valid; block carries the final padding
- Block_ack  input  1  permutation has consumed Block_out this cycle

Behaviour:
- Reset (sync, high): all outputs 0, Block_out 0, word counter 0, state FILL, pad_pending 0. Reset overrides Start.
- Start: same clear as Reset, taking effect at the next edge. It overrides all other inputs in the same cycle.
- States:
  - FILL: accepting words.
  - FULL: block presented.
  - FULL_PAD: block presented, and a pure-padding block still owed.
- FILL, Din_valid=1, Last_block=0:
  - Din written to word[cnt]; cnt increments.
  - If cnt was RATE_WORDS-1, go to FULL next cycle with Buffer_full=Block_valid=1 and Block_last=0. Latency is 1 cycle from the 17th write.
- FILL, Last_block=1 (with or without Din_valid):
  - If Din_valid, the word is written first at word[cnt], then c = cnt+1; otherwise c = cnt.
  - If c < RATE_WORDS:
    - word[c] ^= 0x01 in its low byte; word[16] ^= 0x80 in its top byte (bit 63).
    - Words between c and 16 are zero. When c=16 both marks land in word 16 (0x8000_0000_0000_0001).
    - Go to FULL with Block_last=1.
  - If c == RATE_WORDS, go to FULL_PAD with Block_last=0.
- FULL / FULL_PAD:
  - Block_out held constant. Din_valid and Last_block are ignored (dropped).
  - Buffer_full = Block_valid = 1.
- Block_ack in FULL:
  - Next cycle: buffer zeroed, cnt=0, Buffer_full=Block_valid=Block_last=0, state FILL.
  - Din_valid is not accepted in the ack cycle.
- Block_ack in FULL_PAD:
  - Next cycle: buffer loaded with word0=0x0000_0000_0000_0001, words 1..15 zero, word16=0x8000_0000_0000_0000.
  - State FULL with Block_last=1, Block_valid=1.
- Block_ack while Block_valid=0: ignored.
- After a Block_last block is acked, the block stays in FILL with cnt=0 until the next Start or Din_valid. Words arriving without a new Start begin a new message.
- Block_valid never drops without Block_ack, except on Reset or Start.

Optional Feature:
- Macro: KECCAK_INPUT_BUFFER_OVERFLOW_CHK_EN.
- Defined:
  - Adds output Overflow (1 bit, reset 0).
  - Overflow is a sticky flag set when Din_valid or Last_block is asserted while in FULL/FULL_PAD.
  - Cleared only by Reset or Start.
- Undefined:
  - Port absent.
  - Such inputs are silently dropped; all other behaviour is identical.

Test Plan:
- Reset, Start, then 17 Din_valid words 0x0..0x10: Buffer_full=Block_valid=1 one cycle after the 17th; word[i]=i; Block_last=0. Block_ack → Buffer_full=0 the next cycle, Block_out all zero.
- Start, 3 words 0xAAAA..., then Last_block alone: word3=0x01, word16=0x8000_0000_0000_0000, words 4..15 zero, Block_last=1.
- Start, 16 words, then Last_block alone: word16=0x8000_0000_0000_0001, Block_last=1.
- Start, 16 words, 17th word with Last_block in the same cycle:
  - First block is the 17 data words with Block_last=0.
  - After ack, second block is pure padding (word0=0x01, word16=0x80<<56) with Block_last=1.
- Din_valid=1 with Din=0xDEAD held for 5 cycles while Buffer_full=1: Block_out unchanged; Overflow=1 when the macro is defined.
- Reset asserted while in FULL_PAD mid-message: next cycle all outputs 0, cnt=0. A following 17-word message behaves as in the first scenario.
